// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions.
// Immediate-extension modes, default widths and ALU opcodes.
package mips_pkg;

   localparam int IMM_IN_W  = 16;
   localparam int IMM_OUT_W = 32;

   typedef enum logic [1:0] {
      EXT_HALF  = 2'b00,
      EXT_BYTE  = 2'b01,
      EXT_UPPER = 2'b10,
      EXT_RSVD  = 2'b11
   } ext_mode_e;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'h0,
      ALU_SUB  = 4'h1,
      ALU_AND  = 4'h2,
      ALU_OR   = 4'h3,
      ALU_XOR  = 4'h4,
      ALU_NOR  = 4'h5,
      ALU_SLT  = 4'h6,
      ALU_SLTU = 4'h7,
      ALU_SLL  = 4'h8,
      ALU_SRL  = 4'h9,
      ALU_SRA  = 4'hA,
      ALU_LUI  = 4'hB
   } alu_op_e;

endpackage

// File: rtl/imm_sign_extender_ext_core.sv
// Combinational immediate-extension mux.
// Reserved mode falls back to halfword extension.
module ext_core
   import mips_pkg::*;
#(
   parameter int IN_W  = IMM_IN_W,
   parameter int OUT_W = IMM_OUT_W
) (
   input  logic [IN_W-1:0]  imm_val,
   input  logic             ctrl,
   input  logic [1:0]       mode,
   output logic [OUT_W-1:0] out_val
);

   logic half_fill;
   logic byte_fill;

   assign half_fill = ctrl & imm_val[IN_W-1];
   assign byte_fill = ctrl & imm_val[7];

   // Select the extension form; every branch drives all bits.
   always_comb begin
      out_val = {{(OUT_W-IN_W){half_fill}}, imm_val};
      unique case (mode)
         EXT_BYTE:
            out_val = {{(OUT_W-8){byte_fill}}, imm_val[7:0]};
         EXT_UPPER:
            out_val = {imm_val, {(OUT_W-IN_W){1'b0}}};
         default:
            out_val = {{(OUT_W-IN_W){half_fill}}, imm_val};
      endcase
   end

endmodule

// File: rtl/imm_sign_extender.sv
// Immediate extender with combinational output.
// A capture register provides a registered copy plus valid flag.
module imm_sign_extender
   import mips_pkg::*;
#(
   parameter int IN_W  = IMM_IN_W,
   parameter int OUT_W = IMM_OUT_W
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [IN_W-1:0]  imm_val,
   input  logic             ctrl,
   input  logic [1:0]       mode,
   input  logic             en,
   output logic [OUT_W-1:0] out_val,
   output logic [OUT_W-1:0] out_val_q,
   output logic             out_valid_q
);

   ext_core #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W)
   ) u_core (
      .imm_val (imm_val),
      .ctrl    (ctrl),
      .mode    (mode),
      .out_val (out_val)
   );

   // Capture register; reset wins over enable.
   always_ff @(posedge clock) begin
      if (reset) begin
         out_val_q   <= '0;
         out_valid_q <= 1'b0;
      end else if (en) begin
         out_val_q   <= out_val;
         out_valid_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_imm_sign_extender.sv
// Self-checking bench for imm_sign_extender.
// Directed cases then random traffic against an arithmetic model.
module tb_imm_sign_extender;

   logic        clock;
   logic        reset;
   logic [15:0] imm_val;
   logic        ctrl;
   logic [1:0]  mode;
   logic        en;
   logic [31:0] out_val;
   logic [31:0] out_val_q;
   logic        out_valid_q;

   int checks = 0;
   int errors = 0;

   logic [31:0] exp_q = '0;
   logic        exp_v = 1'b0;

   imm_sign_extender dut (
      .clock       (clock),
      .reset       (reset),
      .imm_val     (imm_val),
      .ctrl        (ctrl),
      .mode        (mode),
      .en          (en),
      .out_val     (out_val),
      .out_val_q   (out_val_q),
      .out_valid_q (out_valid_q)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_ext(input int imm,
                                           input bit c,
                                           input int m);
      longint v;
      int b;
      if (m == 2) begin
         v = longint'(imm) * 65536;
      end else if (m == 1) begin
         b = imm % 256;
         v = (c && b >= 128) ? b - 256 : b;
      end else begin
         v = (c && imm >= 32768) ? imm - 65536 : imm;
      end
      return 32'(v);
   endfunction

   task automatic cycle(input bit r, input bit e,
                        input logic [15:0] imm,
                        input bit c, input logic [1:0] m,
                        input logic [31:0] exp_comb,
                        input string tag);
      logic [31:0] model;
      reset   = r;
      en      = e;
      imm_val = imm;
      ctrl    = c;
      mode    = m;
      #1;
      model = ref_ext(int'(imm), c, int'(m));
      chk({tag, "_comb"}, out_val, exp_comb);
      @(posedge clock);
      if (r) begin
         exp_q = '0;
         exp_v = 1'b0;
      end else if (e) begin
         exp_q = model;
         exp_v = 1'b1;
      end
      #1;
      chk({tag, "_q"}, out_val_q, exp_q);
      chk({tag, "_vq"}, {31'b0, out_valid_q}, {31'b0, exp_v});
   endtask

   initial begin
      logic [15:0] ri;
      bit rc;
      logic [1:0] rm;
      reset = 1'b1;
      en = 1'b0;
      imm_val = '0;
      ctrl = 1'b0;
      mode = 2'b00;
      @(negedge clock);
      cycle(1, 0, 16'h0000, 0, 2'b00, 32'h0000_0000, "rst");
      cycle(0, 0, 16'h8000, 1, 2'b00, 32'hFFFF_8000, "hs_8000");
      cycle(0, 0, 16'h7FFF, 1, 2'b00, 32'h0000_7FFF, "hs_7fff");
      cycle(0, 0, 16'hFFFF, 0, 2'b00, 32'h0000_FFFF, "hz_ffff");
      cycle(0, 0, 16'h0000, 0, 2'b00, 32'h0000_0000, "hz_0000");
      cycle(0, 0, 16'h1280, 1, 2'b01, 32'hFFFF_FF80, "bs_1280");
      cycle(0, 0, 16'h1280, 0, 2'b01, 32'h0000_0080, "bz_1280");
      cycle(0, 0, 16'hAB7F, 1, 2'b01, 32'h0000_007F, "bs_ab7f");
      cycle(0, 0, 16'h1234, 0, 2'b10, 32'h1234_0000, "up_c0");
      cycle(0, 0, 16'h1234, 1, 2'b10, 32'h1234_0000, "up_c1");
      cycle(0, 0, 16'hFFFE, 1, 2'b11, 32'hFFFF_FFFE, "rsv");
      cycle(0, 0, 16'hFFFE, 0, 2'b11, 32'h0000_FFFE, "rsv_z");
      cycle(0, 1, 16'h8001, 1, 2'b00, 32'hFFFF_8001, "cap");
      cycle(0, 0, 16'h00FF, 1, 2'b01, 32'hFFFF_FFFF, "hold");
      cycle(1, 1, 16'h8001, 1, 2'b00, 32'hFFFF_8001, "rst_en");
      for (int i = 0; i < 400; i++) begin
         ri = 16'($urandom);
         rc = 1'($urandom);
         rm = 2'($urandom);
         cycle(($urandom_range(0, 15) == 0), 1'($urandom),
               ri, rc, rm, ref_ext(int'(ri), rc, int'(rm)), "rnd");
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
